// File: rtl/turn_sequencer_pkg.sv
// Shared definitions for the chicken race turn sequencer: track geometry,
// player-count limits, FSM state encoding and small helpers.
package turn_sequencer_pkg;

  localparam int NUM_TILES   = 24;
  localparam int MAX_PLAYERS = 4;
  localparam int POS_W       = 5;
  localparam int TAIL_W      = 3;

  localparam logic [2:0] N_MIN = 3'd2;
  localparam logic [2:0] N_MAX = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_WAIT_FLIP = 3'd2,
    S_MOVE      = 3'd3,
    S_SETTLE    = 3'd4,
    S_CHECK     = 3'd5,
    S_NEXT      = 3'd6,
    S_WIN       = 3'd7
  } state_e;

  function automatic logic [2:0] clamp_players(input logic [4:0] n);
    logic [2:0] r;
    if (n < {2'b00, N_MIN}) begin
      r = N_MIN;
    end else if (n > {2'b00, N_MAX}) begin
      r = N_MAX;
    end else begin
      r = n[2:0];
    end
    return r;
  endfunction

  // Every active player starts the game owning exactly its own tail.
  function automatic logic [MAX_PLAYERS*TAIL_W-1:0] init_tails(input logic [2:0] n);
    logic [MAX_PLAYERS*TAIL_W-1:0] t;
    t = {(MAX_PLAYERS*TAIL_W){1'b0}};
    for (int k = 0; k < MAX_PLAYERS; k++) begin
      if (k < int'(n)) begin
        t[k*TAIL_W +: TAIL_W] = 3'd1;
      end else begin
        t[k*TAIL_W +: TAIL_W] = 3'd0;
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/turn_sequencer_capture_detect.sv
// Finds the lowest-index active opponent that still holds tails and shares
// the current player's tile.
module turn_sequencer_capture_detect
  import turn_sequencer_pkg::*;
(
  input  logic [MAX_PLAYERS*POS_W-1:0]  pos,
  input  logic [1:0]                    cur_player,
  input  logic [2:0]                    num_players,
  input  logic [MAX_PLAYERS*TAIL_W-1:0] tails,
  output logic                          hit,
  output logic [1:0]                    victim
);

  logic [POS_W-1:0] cur_pos;

  always_comb begin
    hit     = 1'b0;
    victim  = 2'd0;
    cur_pos = pos[cur_player*POS_W +: POS_W];
    for (int j = 0; j < MAX_PLAYERS; j++) begin
      if (!hit && (j != int'(cur_player)) && (j < int'(num_players)) &&
          (tails[j*TAIL_W +: TAIL_W] != 3'd0) &&
          (pos[j*POS_W +: POS_W] == cur_pos)) begin
        hit    = 1'b1;
        victim = 2'(j);
      end else begin
        hit    = hit;
      end
    end
  end

endmodule

// File: rtl/turn_sequencer.sv
// Game-flow controller: sequences turns, strobes the position counters,
// resolves tail captures and declares the winner.
module turn_sequencer
  import turn_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  N,
  input  logic        flip_valid,
  input  logic        flip_match,
  input  logic [19:0] pos,
  output logic        pos_load,
  output logic [3:0]  p_da,
  output logic        move_stb,
  output logic [1:0]  cur_player,
  output logic [11:0] tails,
  output logic [7:0]  turn_cnt,
  output logic [2:0]  winner,
  output logic        game_over
);

  state_e      state_q, state_d;
  logic [2:0]  n_q, n_d;
  logic [1:0]  cur_q, cur_d;
  logic [11:0] tails_q, tails_d;
  logic [7:0]  turn_q, turn_d;
  logic [2:0]  winner_q, winner_d;
  logic [3:0]  p_da_q, p_da_d;
  logic        move_stb_q, move_stb_d;
  logic        pos_load_q, pos_load_d;
  logic        game_over_q, game_over_d;

  logic              hit;
  logic [1:0]        victim;
  logic [TAIL_W-1:0] cur_tails;
  logic [TAIL_W-1:0] vic_tails;

  turn_sequencer_capture_detect u_capture (
    .pos         (pos),
    .cur_player  (cur_q),
    .num_players (n_q),
    .tails       (tails_q),
    .hit         (hit),
    .victim      (victim)
  );

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    cur_d     = cur_q;
    tails_d   = tails_q;
    turn_d    = turn_q;
    winner_d  = winner_q;
    cur_tails = tails_q[cur_q*TAIL_W +: TAIL_W];
    vic_tails = tails_q[victim*TAIL_W +: TAIL_W];

    case (state_q)
      S_IDLE, S_WIN: begin
        if (start) begin
          state_d  = S_LOAD;
          n_d      = clamp_players(N);
          cur_d    = 2'd0;
          tails_d  = init_tails(clamp_players(N));
          turn_d   = 8'd0;
          winner_d = 3'd0;
        end else begin
          state_d = state_q;
        end
      end
      S_LOAD:   state_d = S_WAIT_FLIP;
      S_WAIT_FLIP: begin
        if (flip_valid) begin
          state_d = flip_match ? S_MOVE : S_NEXT;
        end else begin
          state_d = S_WAIT_FLIP;
        end
      end
      S_MOVE:   state_d = S_SETTLE;
      S_SETTLE: state_d = S_CHECK;
      S_CHECK: begin
        // At most one victim per move; the mover absorbs all of its tails.
        if (hit) begin
          cur_tails = cur_tails + vic_tails;
          tails_d[victim*TAIL_W +: TAIL_W] = 3'd0;
          tails_d[cur_q*TAIL_W +: TAIL_W]  = cur_tails;
        end else begin
          cur_tails = cur_tails;
        end
        if (cur_tails == n_q) begin
          state_d  = S_WIN;
          winner_d = {1'b0, cur_q} + 3'd1;
        end else begin
          state_d = S_WAIT_FLIP;
        end
      end
      S_NEXT: begin
        state_d = S_WAIT_FLIP;
        if (({1'b0, cur_q} + 3'd1) >= n_q) begin
          cur_d = 2'd0;
        end else begin
          cur_d = cur_q + 2'd1;
        end
        if (turn_q != 8'hFF) begin
          turn_d = turn_q + 8'd1;
        end else begin
          turn_d = turn_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the upcoming state.
    if ((state_d == S_WAIT_FLIP) || (state_d == S_MOVE) ||
        (state_d == S_SETTLE) || (state_d == S_CHECK)) begin
      p_da_d = 4'b0001 << cur_d;
    end else begin
      p_da_d = 4'b0000;
    end
    move_stb_d  = (state_d == S_MOVE);
    pos_load_d  = (state_d == S_LOAD);
    game_over_d = (state_d == S_WIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      n_q         <= N_MIN;
      cur_q       <= 2'd0;
      tails_q     <= 12'b001_001_001_001;
      turn_q      <= 8'd0;
      winner_q    <= 3'd0;
      p_da_q      <= 4'b0000;
      move_stb_q  <= 1'b0;
      pos_load_q  <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      cur_q       <= cur_d;
      tails_q     <= tails_d;
      turn_q      <= turn_d;
      winner_q    <= winner_d;
      p_da_q      <= p_da_d;
      move_stb_q  <= move_stb_d;
      pos_load_q  <= pos_load_d;
      game_over_q <= game_over_d;
    end
  end

  assign pos_load   = pos_load_q;
  assign p_da       = p_da_q;
  assign move_stb   = move_stb_q;
  assign cur_player = cur_q;
  assign tails      = tails_q;
  assign turn_cnt   = turn_q;
  assign winner     = winner_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Self-checking bench for turn_sequencer: directed scenarios followed by
// randomized games compared against a turn-level reference model.
module tb_turn_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  N;
  logic        flip_valid;
  logic        flip_match;
  logic [4:0]  bp [4];
  logic [19:0] pos;
  logic        pos_load;
  logic [3:0]  p_da;
  logic        move_stb;
  logic [1:0]  cur_player;
  logic [11:0] tails;
  logic [7:0]  turn_cnt;
  logic [2:0]  winner;
  logic        game_over;

  assign pos = {bp[3], bp[2], bp[1], bp[0]};

  turn_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .N          (N),
    .flip_valid (flip_valid),
    .flip_match (flip_match),
    .pos        (pos),
    .pos_load   (pos_load),
    .p_da       (p_da),
    .move_stb   (move_stb),
    .cur_player (cur_player),
    .tails      (tails),
    .turn_cnt   (turn_cnt),
    .winner     (winner),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: game state at turn granularity.
  int m_n, m_cur, m_turn, m_win;
  int m_tails [4];
  bit m_over, m_active;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] pack_tails();
    logic [11:0] t;
    t = 12'd0;
    for (int k = 0; k < 4; k++) t[3*k +: 3] = 3'(m_tails[k]);
    return t;
  endfunction

  task automatic check_state(input string tag);
    logic [3:0] exp_pda;
    exp_pda = 4'b0000;
    if (m_active && !m_over) exp_pda[m_cur] = 1'b1;
    check_eq({tag, ".cur"},   32'(cur_player), 32'(m_cur));
    check_eq({tag, ".tails"}, 32'(tails),      32'(pack_tails()));
    check_eq({tag, ".turn"},  32'(turn_cnt),   32'(m_turn));
    check_eq({tag, ".win"},   32'(winner),     32'(m_win));
    check_eq({tag, ".over"},  32'(game_over),  32'(m_over));
    check_eq({tag, ".pda"},   32'(p_da),       32'(exp_pda));
    check_eq({tag, ".stb"},   32'(move_stb),   32'd0);
  endtask

  task automatic model_reset();
    m_n = 2; m_cur = 0; m_turn = 0; m_win = 0; m_over = 1'b0; m_active = 1'b0;
    for (int k = 0; k < 4; k++) m_tails[k] = 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; flip_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_state("reset");
    check_eq("reset.load", 32'(pos_load), 32'd0);
  endtask

  task automatic do_start(input logic [4:0] n);
    start = 1'b1; N = n;
    @(negedge clk);
    start = 1'b0; N = 5'($urandom_range(0, 31));
    m_n = (n < 5'd2) ? 2 : ((n > 5'd4) ? 4 : int'(n));
    m_cur = 0; m_turn = 0; m_win = 0; m_over = 1'b0; m_active = 1'b1;
    for (int k = 0; k < 4; k++) m_tails[k] = (k < m_n) ? 1 : 0;
    check_eq("load.pulse", 32'(pos_load), 32'd1);
    check_eq("load.pda",   32'(p_da),     32'd0);
    for (int k = 0; k < 4; k++) bp[k] = 5'((k * 24) / m_n);
    @(negedge clk);
    check_eq("load.end", 32'(pos_load), 32'd0);
    check_state("started");
  endtask

  task automatic apply_move();
    bit found;
    found = 1'b0;
    for (int j = 0; j < m_n; j++) begin
      if (!found && j != m_cur && m_tails[j] > 0 && bp[j] == bp[m_cur]) begin
        found = 1'b1;
        m_tails[m_cur] += m_tails[j];
        m_tails[j] = 0;
      end
    end
    if (m_tails[m_cur] == m_n) begin
      m_over = 1'b1;
      m_win  = m_cur + 1;
    end
  endtask

  // Called at a negedge with the DUT waiting for a flip.
  task automatic do_flip(input bit match, input bit stray);
    logic [3:0] exp_pda;
    exp_pda = 4'b0000;
    exp_pda[m_cur] = 1'b1;
    flip_valid = 1'b1; flip_match = match;
    @(negedge clk);
    flip_valid = 1'b0; flip_match = 1'($urandom_range(0, 1));
    if (match) begin
      check_eq("move.stb", 32'(move_stb), 32'd1);
      check_eq("move.pda", 32'(p_da),     32'(exp_pda));
      bp[m_cur] = 5'((int'(bp[m_cur]) + 1) % 24);
      flip_valid = stray;
      @(negedge clk);
      flip_valid = 1'b0;
      check_eq("settle.stb", 32'(move_stb), 32'd0);
      @(negedge clk);
      @(negedge clk);
      apply_move();
      check_state("after_match");
    end else begin
      check_eq("next.stb", 32'(move_stb), 32'd0);
      @(negedge clk);
      m_cur = (m_cur + 1) % m_n;
      if (m_turn < 255) m_turn++;
      check_state("after_miss");
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; N = 5'd0; flip_valid = 1'b0; flip_match = 1'b0;
    for (int k = 0; k < 4; k++) bp[k] = 5'd0;
    model_reset();

    // Three players: start-up values.
    do_reset();
    do_start(5'd3);
    check_eq("n3.tails", 32'(tails), 32'h049);

    // Two players: handovers and a plain move.
    do_reset();
    do_start(5'd2);
    do_flip(1'b0, 1'b0);
    check_eq("n2.turn1", 32'(turn_cnt), 32'd1);
    do_flip(1'b0, 1'b0);
    check_eq("n2.cur0", 32'(cur_player), 32'd0);
    bp[0] = 5'd0; bp[1] = 5'd10;
    do_flip(1'b1, 1'b0);

    // Four players: player 0 steps onto player 2.
    do_reset();
    do_start(5'd4);
    bp[0] = 5'd4; bp[1] = 5'd9; bp[2] = 5'd5; bp[3] = 5'd15;
    do_flip(1'b1, 1'b0);
    check_eq("n4.capture", 32'(tails), 32'h20A);

    // Two players: player 1 captures and wins; flips ignored in WIN.
    do_reset();
    do_start(5'd2);
    do_flip(1'b0, 1'b0);
    bp[0] = 5'd7; bp[1] = 5'd6;
    do_flip(1'b1, 1'b1);
    check_eq("win.winner", 32'(winner), 32'd2);
    flip_valid = 1'b1; flip_match = 1'b1;
    @(negedge clk);
    flip_valid = 1'b0;
    @(negedge clk);
    check_state("win_hold");
    do_start(5'd2);
    check_eq("restart.tails", 32'(tails), 32'h009);

    // Clamp above 4, rotation and turn counter saturation.
    do_reset();
    do_start(5'd7);
    repeat (3) do_flip(1'b0, 1'b0);
    check_eq("n7.cur3", 32'(cur_player), 32'd3);
    do_flip(1'b0, 1'b0);
    check_eq("n7.wrap", 32'(cur_player), 32'd0);
    repeat (256) do_flip(1'b0, 1'b0);
    check_eq("turn.sat", 32'(turn_cnt), 32'd255);

    // Reset while the move strobe is high.
    flip_valid = 1'b1; flip_match = 1'b1;
    @(negedge clk);
    flip_valid = 1'b0;
    check_eq("pre_rst.stb", 32'(move_stb), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_state("rst_move");
    @(negedge clk);
    check_state("rst_move2");

    // Reset coinciding with a matching flip.
    do_start(5'd3);
    rst = 1'b1; flip_valid = 1'b1; flip_match = 1'b1;
    @(negedge clk);
    rst = 1'b0; flip_valid = 1'b0;
    model_reset();
    check_state("rst_flip");

    // Randomized games.
    for (int g = 0; g < 40; g++) begin
      if (!m_over) do_reset();
      do_start(5'($urandom_range(0, 31)));
      for (int f = 0; f < 40 && !m_over; f++) begin
        int idle;
        for (int k = 0; k < 4; k++) bp[k] = 5'((22 + $urandom_range(0, 4)) % 24);
        idle = int'($urandom_range(0, 2));
        repeat (idle) @(negedge clk);
        if (idle > 0) check_state("idle_hold");
        do_flip(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/turn_sequencer.md
Name: turn_sequencer

Overview:
- Game-flow controller for the chicken race board.
- Decides whose turn it is and drives each player's position counter, through a one-hot move enable plus a move strobe used as that counter's step clock.
- Tracks tail ownership, detects captures and declares the winner.
- Sits between the card-flip logic (match/mismatch results) and the four per-player position counters on the 24-tile track.

Parameters:
- NUM_TILES, 24, track length; positions wrap 23 -> 0.
- MAX_PLAYERS, 4, number of player slots.
- POS_W, 5, position width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level; begins or restarts a game when sampled high in IDLE or WIN.
- N  in  5  player count, latched on start; values below 2 clamp to 2, values above 4 clamp to 4.
- flip_valid  in  1  single-cycle pulse: a card flip result is ready.
- flip_match  in  1  qualifies flip_valid; 1 = card matches the tile ahead.
- pos  in  20  packed positions; player k at bits [5k+4:5k], k = 0..3.
- pos_load  out  1  single-cycle pulse; position counters reload their N-dependent start tiles.
- p_da  out  4  one-hot move enable for the current player; 0 in IDLE and WIN.
- move_stb  out  1  single-cycle strobe; a counter with p_da set advances one tile.
- cur_player  out  2  index of the current player, 0..3.
- tails  out  12  packed 3-bit tail count per player; player k at bits [3k+2:3k].
- turn_cnt  out  8  number of turn handovers, saturates at 255.
- winner  out  3  0 = none; otherwise winning player index + 1.
- game_over  out  1  high in WIN.

Behaviour:
- Reset values: state IDLE, cur_player 0, p_da 0, move_stb 0, pos_load 0, every tail count 1, turn_cnt 0, winner 0, game_over 0, latched N 2.
- rst has priority in every state and aborts any operation in progress, including a pending strobe.
- States: IDLE, LOAD, WAIT_FLIP, MOVE, SETTLE, CHECK, NEXT, WIN.
- IDLE: on start -> LOAD. Latch clamped N, set cur_player 0, set tails = 1 for players below N and 0 for the rest, clear turn_cnt and winner.
- LOAD: pos_load = 1 for exactly one cycle -> WAIT_FLIP.
- WAIT_FLIP:
  - p_da = one-hot(cur_player).
  - flip_valid & flip_match -> MOVE.
  - flip_valid & !flip_match -> NEXT.
  - flip_valid outside WAIT_FLIP is ignored; it is not queued.
- MOVE: move_stb = 1 for one cycle, p_da held -> SETTLE.
- SETTLE: one idle cycle so the counter update is visible on pos -> CHECK.
- CHECK (single cycle):
  - Candidates: players j != cur_player, j below N, tails[j] > 0, pos[j] == pos[cur].
  - If any exist, the lowest-index candidate j is captured: tails[cur] += tails[j], tails[j] = 0.
  - At most one capture per move.
  - Then: tails[cur] == N (all tails held) -> WIN, else -> WAIT_FLIP. The same player keeps the turn after a match.
- NEXT: cur_player = (cur_player + 1) mod N; turn_cnt += 1, saturating -> WAIT_FLIP.
- WIN: game_over = 1, winner = cur_player + 1, p_da = 0. Holds until start -> LOAD (with the same latch actions as IDLE) or until rst.
- Arithmetic: tail counts never exceed 4; the sum over active players always equals N. Position comparisons are 5-bit equality; wrap-around is the counters' responsibility.
- Players with 0 tails keep taking turns and can still recapture.
- Latency: flip match to move_stb is 1 cycle; flip to the next WAIT_FLIP is 4 cycles on a match, 2 on a mismatch.

Decomposition:
- Shared package holds:
  - state encoding;
  - NUM_TILES, MAX_PLAYERS, POS_W, TAIL_W = 3;
  - the N clamp constants 2 and 4.
- One sub-module, capture_detect: combinational lowest-index match of pos[cur] against active players that still hold tails. It outputs hit and a 2-bit victim index.

Test Plan:
- rst, then start with N = 3 -> pos_load pulses 1 cycle; cur_player 0; p_da 0001; tails = {0,1,1,1}.
- N = 2, mismatch flip -> cur_player 1, turn_cnt 1; second mismatch -> cur_player 0, turn_cnt 2.
- Match flip with player 0 -> move_stb exactly 1 cycle after flip_valid, with p_da 0001; cur_player stays 0.
- N = 4, pos drives player 0 onto player 2's tile after a move -> tails[2] = 0, tails[0] = 2, turn retained.
- N = 2, player 1 captures player 0 -> tails[1] = 2 = N; winner 2, game_over 1, p_da 0; flip_valid ignored. start -> LOAD, tails restored to {0,0,1,1}.
- N = 7 on start -> behaves as N = 4; three mismatches from player 0 -> cur_player 3, fourth -> 0. rst during MOVE -> no move_stb, all outputs at reset values next cycle.
